btb_ctrl: RTL and testbench

Request controller and replacement engine for the 8-entry fully associative branch target buffer. It arbitrates between fetch-stage lookups and execute-stage updates for the single-ported tag/target arrays. It owns the valid bits and the per-line true-LRU age state, and it selects the victim line on allocation. It sits between the IF stage, the EX stage and the BTB storage.

---
 rtl/btb_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_btb_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_ctrl.sv
// Request controller and true-LRU replacement engine for a small fully associative BTB.
// Arbitrates IF lookups against EX updates and owns the valid, tag, target and age state.
module btb_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_NUM   = 8,
    parameter int unsigned LINE_SIZE  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [DATA_WIDTH-1:0] lookup_pc,
    output logic                  lookup_ready,
    output logic                  lookup_resp_valid,
    output logic                  lookup_hit,
    output logic [DATA_WIDTH-1:0] lookup_target,
    output logic [LINE_SIZE-1:0]  lookup_line,
    input  logic                  update_valid,
    input  logic [DATA_WIDTH-1:0] update_pc,
    input  logic [DATA_WIDTH-1:0] update_target,
    output logic                  update_ready,
    output logic                  update_done,
    output logic [LINE_SIZE-1:0]  update_line
);

    typedef enum logic [1:0] {StIdle, StLookup, StUpdSearch, StUpdWrite} state_e;

    localparam logic GrantLookup = 1'b0;
    localparam logic GrantUpdate = 1'b1;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [DATA_WIDTH-1:0] req_target_q, req_target_d;
    logic [LINE_NUM-1:0]   valid_q, valid_d;
    logic [DATA_WIDTH-1:0] tag_q [LINE_NUM];
    logic [DATA_WIDTH-1:0] tag_d [LINE_NUM];
    logic [DATA_WIDTH-1:0] tgt_q [LINE_NUM];
    logic [DATA_WIDTH-1:0] tgt_d [LINE_NUM];
    logic [LINE_SIZE-1:0]  age_q [LINE_NUM];
    logic [LINE_SIZE-1:0]  age_d [LINE_NUM];
    logic [LINE_SIZE-1:0]  sel_line_q, sel_line_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  hit_q, hit_d;
    logic [DATA_WIDTH-1:0] resp_target_q, resp_target_d;
    logic [LINE_SIZE-1:0]  resp_line_q, resp_line_d;
    logic                  done_q, done_d;
    logic [LINE_SIZE-1:0]  upd_line_q, upd_line_d;

    logic                  match_any;
    logic [LINE_SIZE-1:0]  match_line;
    logic                  free_any;
    logic [LINE_SIZE-1:0]  free_line;
    logic [LINE_SIZE-1:0]  lru_line;
    logic                  touch_en;
    logic [LINE_SIZE-1:0]  touch_line;

    assign lookup_ready = !rst && (state_q == StIdle) &&
                          !(update_valid && (last_grant_q == GrantLookup));
    assign update_ready = !rst && (state_q == StIdle) &&
                          !(lookup_valid && (last_grant_q == GrantUpdate));

    assign lookup_resp_valid = resp_valid_q;
    assign lookup_hit        = hit_q;
    assign lookup_target     = resp_target_q;
    assign lookup_line       = resp_line_q;
    assign update_done       = done_q;
    assign update_line       = upd_line_q;

    // Tag match, lowest free line and LRU line, all against the latched request PC.
    always_comb begin
        match_any  = 1'b0;
        match_line = '0;
        free_any   = 1'b0;
        free_line  = '0;
        lru_line   = '0;
        for (int i = 0; i < LINE_NUM; i++) begin
            if (valid_q[i] && (tag_q[i] == req_pc_q)) begin
                match_any  = 1'b1;
                match_line = LINE_SIZE'(i);
            end
            if (age_q[i] == LINE_SIZE'(LINE_NUM - 1)) begin
                lru_line = LINE_SIZE'(i);
            end
        end
        for (int i = LINE_NUM - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any  = 1'b1;
                free_line = LINE_SIZE'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        req_pc_d      = req_pc_q;
        req_target_d  = req_target_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        tgt_d         = tgt_q;
        sel_line_d    = sel_line_q;
        resp_valid_d  = 1'b0;
        hit_d         = hit_q;
        resp_target_d = resp_target_q;
        resp_line_d   = resp_line_q;
        done_d        = 1'b0;
        upd_line_d    = upd_line_q;
        touch_en      = 1'b0;
        touch_line    = '0;
        case (state_q)
            StIdle: begin
                if (lookup_valid && lookup_ready) begin
                    state_d      = StLookup;
                    req_pc_d     = lookup_pc;
                    last_grant_d = GrantLookup;
                end else if (update_valid && update_ready) begin
                    state_d      = StUpdSearch;
                    req_pc_d     = update_pc;
                    req_target_d = update_target;
                    last_grant_d = GrantUpdate;
                end
            end
            StLookup: begin
                resp_valid_d  = 1'b1;
                hit_d         = match_any;
                resp_target_d = match_any ? tgt_q[match_line] : '0;
                resp_line_d   = match_any ? match_line : '0;
                touch_en      = match_any;
                touch_line    = match_line;
                state_d       = StIdle;
            end
            StUpdSearch: begin
                // Existing entry first, then the lowest free line, then the LRU victim.
                if (match_any) begin
                    sel_line_d = match_line;
                end else if (free_any) begin
                    sel_line_d = free_line;
                end else begin
                    sel_line_d = lru_line;
                end
                state_d = StUpdWrite;
            end
            StUpdWrite: begin
                valid_d[sel_line_q] = 1'b1;
                tag_d[sel_line_q]   = req_pc_q;
                tgt_d[sel_line_q]   = req_target_q;
                touch_en            = 1'b1;
                touch_line          = sel_line_q;
                done_d              = 1'b1;
                upd_line_d          = sel_line_q;
                state_d             = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Touch keeps the ages a permutation: younger lines shift back by one, touched line to 0.
    always_comb begin
        for (int i = 0; i < LINE_NUM; i++) begin
            age_d[i] = age_q[i];
            if (touch_en) begin
                if (LINE_SIZE'(i) == touch_line) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[touch_line]) begin
                    age_d[i] = age_q[i] + LINE_SIZE'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            last_grant_q  <= GrantUpdate;
            req_pc_q      <= '0;
            req_target_q  <= '0;
            valid_q       <= '0;
            sel_line_q    <= '0;
            resp_valid_q  <= 1'b0;
            hit_q         <= 1'b0;
            resp_target_q <= '0;
            resp_line_q   <= '0;
            done_q        <= 1'b0;
            upd_line_q    <= '0;
            for (int i = 0; i < LINE_NUM; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                age_q[i] <= LINE_SIZE'(i);
            end
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            req_pc_q      <= req_pc_d;
            req_target_q  <= req_target_d;
            valid_q       <= valid_d;
            sel_line_q    <= sel_line_d;
            resp_valid_q  <= resp_valid_d;
            hit_q         <= hit_d;
            resp_target_q <= resp_target_d;
            resp_line_q   <= resp_line_d;
            done_q        <= done_d;
            upd_line_q    <= upd_line_d;
            for (int i = 0; i < LINE_NUM; i++) begin
                tag_q[i] <= tag_d[i];
                tgt_q[i] <= tgt_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_btb_ctrl.sv
// Bench for btb_ctrl: a transaction-level model (MRU-ordered list, cycle-stamped events)
// checked against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_btb_ctrl;

    logic        clk;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        lookup_ready;
    logic        lookup_resp_valid;
    logic        lookup_hit;
    logic [31:0] lookup_target;
    logic [2:0]  lookup_line;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_ready;
    logic        update_done;
    logic [2:0]  update_line;

    btb_ctrl #(.DATA_WIDTH(32), .LINE_NUM(8), .LINE_SIZE(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .lookup_ready     (lookup_ready),
        .lookup_resp_valid(lookup_resp_valid),
        .lookup_hit       (lookup_hit),
        .lookup_target    (lookup_target),
        .lookup_line      (lookup_line),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_target    (update_target),
        .update_ready     (update_ready),
        .update_done      (update_done),
        .update_line      (update_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: lru holds line numbers from MRU (front) to LRU (back).
    bit          m_valid [8];
    logic [31:0] m_tag [8];
    logic [31:0] m_tgt [8];
    int          lru[$];
    int          m_last;       // 0: lookup granted last, 1: update
    int          free_cyc, resp_cyc, done_cyc;
    logic        p_hit, h_hit;
    logic [31:0] p_tgt, h_tgt;
    int          p_line, h_line, d_line;
    int          n_acc_lk = 0;
    int          n_acc_up = 0;
    int          grant_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        lru.delete();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            lru.push_back(i);
        end
        m_last   = 1;
        free_cyc = 0;
        resp_cyc = -1;
        done_cyc = -1;
        h_hit    = 1'b0;
        h_tgt    = '0;
        h_line   = 0;
    endtask

    task automatic m_touch(input int l);
        int idx;
        idx = 0;
        for (int k = 0; k < lru.size(); k++) if (lru[k] == l) idx = k;
        lru.delete(idx);
        lru.push_front(l);
    endtask

    task automatic m_lookup(input int c, input logic [31:0] pc);
        p_hit  = 1'b0;
        p_tgt  = '0;
        p_line = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_tag[i] == pc) begin
                p_hit  = 1'b1;
                p_tgt  = m_tgt[i];
                p_line = i;
            end
        end
        if (p_hit) m_touch(p_line);
        resp_cyc = c + 2;
        free_cyc = c + 2;
        m_last   = 0;
        n_acc_lk++;
        grant_log.push_back(0);
    endtask

    task automatic m_update(input int c, input logic [31:0] pc, input logic [31:0] tgt);
        int l;
        l = -1;
        for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == pc) l = i;
        if (l < 0) for (int i = 7; i >= 0; i--) if (!m_valid[i]) l = i;
        if (l < 0) l = lru[lru.size() - 1];
        m_valid[l] = 1'b1;
        m_tag[l]   = pc;
        m_tgt[l]   = tgt;
        m_touch(l);
        d_line   = l;
        done_cyc = c + 3;
        free_cyc = c + 3;
        m_last   = 1;
        n_acc_up++;
        grant_log.push_back(1);
    endtask

    // Compare process: checks all outputs every cycle, then advances the model.
    initial begin : compare
        int   cyc;
        logic e_resp, e_done, e_idle, e_lr, e_ur;
        m_reset();
        cyc = 0;
        forever begin
            @(negedge clk);
            e_resp = (cyc == resp_cyc);
            if (e_resp) begin
                h_hit  = p_hit;
                h_tgt  = p_tgt;
                h_line = p_line;
            end
            e_done = (cyc == done_cyc);
            e_idle = !rst && (cyc >= free_cyc);
            e_lr   = e_idle && !(update_valid && m_last == 0);
            e_ur   = e_idle && !(lookup_valid && m_last == 1);
            chk("lookup_ready", 32'(lookup_ready), 32'(e_lr));
            chk("update_ready", 32'(update_ready), 32'(e_ur));
            chk("lookup_resp_valid", 32'(lookup_resp_valid), 32'(e_resp));
            chk("lookup_hit", 32'(lookup_hit), 32'(h_hit));
            chk("lookup_target", lookup_target, h_tgt);
            chk("lookup_line", 32'(lookup_line), 32'(h_line));
            chk("update_done", 32'(update_done), 32'(e_done));
            if (e_done) chk("update_line", 32'(update_line), 32'(d_line));
            if (rst) m_reset();
            else if (lookup_valid && e_lr) m_lookup(cyc, lookup_pc);
            else if (update_valid && e_ur) m_update(cyc, update_pc, update_target);
            cyc++;
        end
    end

    // Each stimulus task returns #1 after the edge that follows acceptance.
    task automatic do_lookup(input logic [31:0] pc);
        int n0;
        n0 = n_acc_lk;
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        for (int k = 0; k < 40 && n_acc_lk == n0; k++) begin
            @(posedge clk);
            #1;
        end
        if (n_acc_lk == n0) chk("lookup_accept_timeout", 32'(n_acc_lk), 32'(n0 + 1));
        lookup_valid = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt);
        int n0;
        n0 = n_acc_up;
        update_valid  = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        for (int k = 0; k < 40 && n_acc_up == n0; k++) begin
            @(posedge clk);
            #1;
        end
        if (n_acc_up == n0) chk("update_accept_timeout", 32'(n_acc_up), 32'(n0 + 1));
        update_valid = 1'b0;
    endtask

    // Literal expectations for the response in T+2, checked on the DUT and the model.
    task automatic chk_lk(input logic hit, input logic [31:0] tgt, input int line);
        @(negedge clk);
        @(negedge clk);
        chk("lit_resp_valid", 32'(lookup_resp_valid), 32'd1);
        chk("lit_hit", 32'(lookup_hit), 32'(hit));
        chk("lit_target", lookup_target, tgt);
        chk("lit_line", 32'(lookup_line), 32'(line));
        chk("model_hit", 32'(p_hit), 32'(hit));
        chk("model_target", p_tgt, tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_up(input int line);
        repeat (3) @(negedge clk);
        chk("lit_update_done", 32'(update_done), 32'd1);
        chk("lit_update_line", 32'(update_line), 32'(line));
        chk("model_update_line", 32'(d_line), 32'(line));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : stimulus
        rst           = 1'b1;
        lookup_valid  = 1'b0;
        lookup_pc     = '0;
        update_valid  = 1'b0;
        update_pc     = '0;
        update_target = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Miss on an empty BTB leaves the age order untouched.
        do_lookup(32'h100);
        chk_lk(1'b0, 32'h0, 0);
        chk("model_mru_after_miss", 32'(lru[0]), 32'd0);
        chk("model_lru_after_miss", 32'(lru[7]), 32'd7);

        do_update(32'h100, 32'h200);
        chk_up(0);
        do_lookup(32'h100);
        chk_lk(1'b1, 32'h200, 0);

        // Fill all lines, touch line 0, then allocate: line 1 is the victim.
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            do_update(32'(i * 16), 32'h1000 + 32'(i));
            chk_up(i);
        end
        do_lookup(32'h000);
        chk_lk(1'b1, 32'h1000, 0);
        do_update(32'h080, 32'h2080);
        chk_up(1);
        do_lookup(32'h010);
        chk_lk(1'b0, 32'h0, 0);

        // Existing PC overwrites in place.
        do_update(32'h030, 32'h999);
        chk_up(3);
        do_lookup(32'h030);
        chk_lk(1'b1, 32'h999, 3);

        // Both requesters held: grants alternate, lookup first.
        reset_pulse();
        grant_log.delete();
        lookup_valid  = 1'b1;
        lookup_pc     = 32'h500;
        update_valid  = 1'b1;
        update_pc     = 32'h500;
        update_target = 32'h5000;
        repeat (20) @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("grant_order_%0d", k),
                32'(k < grant_log.size() ? grant_log[k] : 99), 32'(k % 2));
        end

        // Reset during UPD_WRITE: no done pulse, array invalidated, ages restored.
        reset_pulse();
        do_update(32'h111, 32'h222);
        chk_up(0);
        do_update(32'h333, 32'h444);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_done_t2", 32'(update_done), 32'd0);
        @(negedge clk);
        chk("abort_done_t3", 32'(update_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("model_lru_reset_first", 32'(lru[0]), 32'd0);
        chk("model_lru_reset_last", 32'(lru[7]), 32'd7);
        do_lookup(32'h111);
        chk_lk(1'b0, 32'h0, 0);
        do_lookup(32'h333);
        chk_lk(1'b0, 32'h0, 0);
        do_update(32'h333, 32'h444);
        chk_up(0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
